// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD helpers for the countdown timer
package bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_dn.sv
// bcd_digit_dn: one BCD digit of the decrement borrow chain
module bcd_digit_dn
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       bin,
  output logic [3:0] digit_out,
  output logic       bout
);
  assign bout = bin && digit_in == 4'd0;
  assign digit_out = !bin ? digit_in : bout ? BCD_MAX : digit_in - 4'd1;
endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: multi-digit BCD countdown timer with one-shot done pulse
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                load_err
);
  state_t state, state_n;
  logic [4*DIGITS-1:0] dec, count_n;
  logic [DIGITS:0] b;
  logic valid, zero, done_n, err_n;
  assign b[0] = tick;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_dn u_dig (
      .digit_in (count[4*g+:4]),
      .bin      (b[g]),
      .digit_out(dec[4*g+:4]),
      .bout     (b[g+1])
    );
  end
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) valid = valid && is_bcd(load_val[4*i+:4]);
  end
  assign zero = count == '0;
  // A borrow out of the top digit means the count is already zero: never wrap.
  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (load) begin
      count_n = valid ? load_val : count;
      state_n = valid ? IDLE : state;
      err_n   = !valid;
    end else if (start) begin
      if (state == IDLE || state == PAUSED) begin
        state_n = zero ? DONE : RUN;
        done_n  = zero;
      end
    end else if (pause) begin
      state_n = state == RUN ? PAUSED : state;
    end else if (tick && state == RUN && !b[DIGITS]) begin
      count_n = dec;
      state_n = dec == '0 ? DONE : RUN;
      done_n  = dec == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      busy     <= state_n == RUN || state_n == PAUSED;
      done     <= done_n;
      load_err <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed self-checking bench for bcd_countdown
module tb_bcd_countdown;
  logic clk = 1'b0;
  logic rst, load, start, pause, tick;
  logic [15:0] load_val, count;
  logic busy, done, load_err;
  int checks = 0;
  int failures = 0;
  bcd_countdown #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count), .busy(busy), .done(done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic step(input logic l, input logic [15:0] lv, input logic s, input logic p, input logic t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] c, input logic b, input logic d, input logic e);
    chk({tag, ".count"}, count, c);
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, d});
    chk({tag, ".load_err"}, {15'd0, load_err}, {15'd0, e});
  endtask
  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    step(0, 16'h0000, 0, 0, 0);
    step(1, 16'h1234, 1, 0, 1);
    chk_all("reset", 16'h0000, 0, 0, 0);
    rst = 1'b1;
    // reset aborts RUN
    step(1, 16'h0042, 0, 0, 0);
    chk_all("t1_load", 16'h0042, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk_all("t1_run", 16'h0042, 1, 0, 0);
    rst = 1'b0;
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t1_rst", 16'h0000, 0, 0, 0);
    rst = 1'b1;
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t1_after", 16'h0000, 0, 0, 0);
    // borrow chain
    step(1, 16'h0103, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t2_102", 16'h0102, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t2_101", 16'h0101, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t2_100", 16'h0100, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t2_099", 16'h0099, 1, 0, 0);
    // reaching zero
    step(1, 16'h0002, 0, 0, 0);
    chk_all("t3_load", 16'h0002, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t3_001", 16'h0001, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t3_zero", 16'h0000, 0, 1, 0);
    step(0, 16'h0000, 0, 0, 0);
    chk_all("t3_pulse_end", 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t3_extra_tick", 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk_all("t3_start_in_done", 16'h0000, 0, 0, 0);
    // invalid load
    step(1, 16'h0A12, 0, 0, 0);
    chk_all("t4_bad", 16'h0000, 0, 0, 1);
    step(0, 16'h0000, 0, 0, 0);
    chk_all("t4_err_end", 16'h0000, 0, 0, 0);
    step(1, 16'h1000, 0, 0, 0);
    chk_all("t4_good", 16'h1000, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t4_borrow_all", 16'h0999, 1, 0, 0);
    step(1, 16'h00F0, 0, 0, 1);
    chk_all("t4_bad_in_run", 16'h0999, 1, 0, 1);
    // pause and resume
    step(1, 16'h0050, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk_all("t5_run", 16'h0050, 1, 0, 0);
    step(0, 16'h0000, 0, 1, 1);
    chk_all("t5_pause", 16'h0050, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 0, 1);
    chk_all("t5_frozen", 16'h0050, 1, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t5_resume", 16'h0049, 1, 0, 0);
    // start from zero and load+start
    step(1, 16'h0000, 0, 0, 0);
    chk_all("t6_load0", 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk_all("t6_start0", 16'h0000, 0, 1, 0);
    step(0, 16'h0000, 0, 0, 0);
    chk_all("t6_pulse_end", 16'h0000, 0, 0, 0);
    step(1, 16'h0005, 1, 0, 0);
    chk_all("t6_load_start", 16'h0005, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("t6_idle_tick", 16'h0005, 0, 0, 0);
    // max value
    step(1, 16'h9999, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    chk_all("max", 16'h9998, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
